// File: rtl/mem_dport.sv
// mem_dport: data-memory port responder between the MEM stage and a
// word-wide external RAM with variable-latency acknowledge.
// Each access runs IDLE -> ACCESS -> DONE; the pipeline is stalled until
// the RAM acks or TIMEOUT cycles elapse in ACCESS.
// Optional feature macro: DPORT_ALIGN_CHECK_EN (reject misaligned requests).
module mem_dport #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req,
   input  logic        mem_memWE,
   input  logic [31:0] mem_opResult,
   input  logic [31:0] mem_memData,
   output logic        dp_stall,
   output logic        dp_done,
   output logic [31:0] dp_rdata,
   output logic        dp_err,
   output logic        ram_ce,
   output logic        ram_we,
   output logic [29:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   input  logic        ram_ack
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q;
   logic       misalign;
   logic       ack_hit;
   logic       to_hit;

`ifdef DPORT_ALIGN_CHECK_EN
   assign misalign = |mem_opResult[1:0];
`else
   // Byte offset is dropped: every request is a word access.
   logic unused_offset;
   assign unused_offset = &{1'b0, mem_opResult[1:0]};
   assign misalign      = 1'b0;
`endif

   // Stall is the only combinational output; held low while in reset.
   assign dp_stall = rst & ((state_q == ACCESS) | ((state_q == IDLE) & mem_req));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state decode; an ack in the timeout cycle takes priority.
   always_comb begin
      state_d = state_q;
      ack_hit = 1'b0;
      to_hit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_req) state_d = misalign ? DONE : ACCESS;
         end
         ACCESS: begin
            ack_hit = ram_ack;
            to_hit  = !ram_ack && (cnt_q == CNT_LAST);
            if (ack_hit || to_hit) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // RAM strobes, wait counter and registered completion outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         ram_ce    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         dp_done   <= 1'b0;
         dp_err    <= 1'b0;
         dp_rdata  <= '0;
      end else begin
         dp_done <= 1'b0;
         dp_err  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (mem_req) begin
                  if (misalign) begin
                     dp_done <= 1'b1;
                     dp_err  <= 1'b1;
                     if (!mem_memWE) dp_rdata <= '0;
                  end else begin
                     ram_ce    <= 1'b1;
                     ram_we    <= mem_memWE;
                     ram_addr  <= mem_opResult[31:2];
                     ram_wdata <= mem_memData;
                     cnt_q     <= '0;
                  end
               end
            end
            ACCESS: begin
               if (cnt_q != '1) cnt_q <= cnt_q + 8'd1;
               if (ack_hit || to_hit) begin
                  ram_ce  <= 1'b0;
                  ram_we  <= 1'b0;
                  dp_done <= 1'b1;
                  dp_err  <= to_hit;
                  // ram_we still holds the access type during ACCESS.
                  if (!ram_we) dp_rdata <= ack_hit ? ram_rdata : '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
